nn_job_ctrl: RTL

//  Control unit behind the UART frame decoder. Buffers the decoder's one-cycle

---
 rtl/nn_job_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/nn_job_ctrl.sv
// rtl/nn_job_ctrl.sv - UART frame to NN job sequencer with ACK/result/NAK/ERR reply.
// Optional frame/NAK statistics counters are built when NN_JOB_STATS_EN is defined.
module nn_job_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [7:0]  ACK_BYTE    = 8'hCC,
  parameter logic [7:0]  NAK_BYTE    = 8'hAA,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic        uart_sampling_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        train,
  input  logic        resend,
  input  logic [7:0]  label,
  output logic        nn_go,
  output logic        nn_train,
  output logic [7:0]  nn_label,
  input  logic        nn_done,
  input  logic [3:0]  nn_result,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] nak_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_REPLY,
    S_NAK
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        train_q;
  logic        start_pend;
  logic [7:0]  pend_label;
  logic [15:0] cyc_cnt;

  logic        launch;
  logic        pend_set;
  logic        tx_load;
  logic [7:0]  tx_load_data;
  logic        time_out;
  logic        overrun;

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    launch       = 1'b0;
    pend_set     = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = 8'h00;
    time_out     = 1'b0;
    overrun      = 1'b0;
    nn_go        = 1'b0;
    tx_valid     = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // resend beats a coincident start; the start is parked until the NAK leaves
        if (resend) begin
          state_nxt    = S_NAK;
          tx_load      = 1'b1;
          tx_load_data = NAK_BYTE;
          pend_set     = start;
        end else if (start || start_pend) begin
          state_nxt = S_LAUNCH;
          launch    = 1'b1;
        end
      end
      S_LAUNCH: begin
        nn_go     = 1'b1;
        overrun   = start;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        overrun = start;
        if (nn_done) begin
          state_nxt    = S_REPLY;
          tx_load      = 1'b1;
          tx_load_data = nn_train ? ACK_BYTE : {4'h0, nn_result};
        end else if (cyc_cnt == (TIMEOUT_CYC - 16'd1)) begin
          state_nxt    = S_REPLY;
          tx_load      = 1'b1;
          tx_load_data = ERR_BYTE;
          time_out     = 1'b1;
        end
      end
      S_REPLY: begin
        tx_valid = 1'b1;
        overrun  = start;
        if (tx_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_NAK: begin
        tx_valid = 1'b1;
        pend_set = start;
        if (tx_ready) begin
          if (start_pend || start) begin
            state_nxt = S_LAUNCH;
            launch    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      train_q     <= 1'b0;
      start_pend  <= 1'b0;
      pend_label  <= 8'h00;
      nn_train    <= 1'b0;
      nn_label    <= 8'h00;
      cyc_cnt     <= 16'd0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // job mode and label only move at launch so the engine sees stable values
      if (launch) begin
        nn_train   <= train_q | train;
        train_q    <= 1'b0;
        nn_label   <= start ? label : pend_label;
        start_pend <= 1'b0;
      end else begin
        if (train) begin
          train_q <= 1'b1;
        end
        if (pend_set) begin
          start_pend <= 1'b1;
          pend_label <= label;
        end
      end
      if (state == S_LAUNCH) begin
        cyc_cnt <= 16'd0;
      end else if (state == S_WAIT) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
      if (tx_load) begin
        tx_data <= tx_load_data;
      end
      if (time_out) begin
        timeout_err <= 1'b1;
      end
      if (overrun) begin
        overrun_err <= 1'b1;
      end
    end
  end

`ifdef NN_JOB_STATS_EN
  logic reply_xfer;
  logic nak_xfer;

  assign reply_xfer = (state == S_REPLY) && tx_ready;
  assign nak_xfer   = (state == S_NAK) && tx_ready;

  always_ff @(posedge uart_sampling_clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      nak_cnt   <= 16'd0;
    end else begin
      if (reply_xfer && (frame_cnt != 16'hFFFF)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (nak_xfer && (nak_cnt != 16'hFFFF)) begin
        nak_cnt <= nak_cnt + 16'd1;
      end
    end
  end
`else
  assign frame_cnt = 16'd0;
  assign nak_cnt   = 16'd0;
`endif

endmodule
